// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: a byte FIFO fed by core stores, drained by an 8N1 serialiser.
// Data register at pBaseAddr (write-only push), status register at pBaseAddr+4.
module uart_tx_mmio #(
  parameter logic [31:0] pBaseAddr = 32'h0000_1000,
  parameter int unsigned pClkDiv   = 32'd16,
  parameter int unsigned pDepth    = 8
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  input  logic [31:0] iwReadAddr,
  output logic [31:0] owReadData,
  output logic        owReadHit,
  output logic        owTx
);

  localparam int unsigned PtrW   = $clog2(pDepth);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(pClkDiv);

  localparam logic [31:0]       StatusAddr = pBaseAddr + 32'd4;
  localparam logic [CntW-1:0]   BitLast    = CntW'(pClkDiv - 1);
  localparam logic [CntW-1:0]   CntOne     = CntW'(1);
  localparam logic [PtrW-1:0]   PtrOne     = PtrW'(1);
  localparam logic [CountW-1:0] CountOne   = CountW'(1);
  localparam logic [CountW-1:0] CountFull  = CountW'(pDepth);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [pDepth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       rdata_q, rdata_d;
  logic              rhit_q, rhit_d;

  logic              push, push_ok, pop, ovf_clr;
  logic              full, empty, busy, cnt_last;
  logic [7:0]        head;
  logic [31:0]       status;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  assign head     = mem_q[rd_ptr_q];
  assign cnt_last = (cnt_q == BitLast);
  assign status   = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, empty, full};

  assign push    = !iwRst && (iwWriteAddr == pBaseAddr) && iwWstrb[0];
  assign ovf_clr = !iwRst && (iwWriteAddr == StatusAddr) && iwWstrb[0] && iwWriteData[3];
  // A full FIFO still accepts a byte when the serialiser frees a slot on the same edge.
  assign push_ok = push && (!full || pop);

  // Serialiser sequencing; pop is only ever raised while the FIFO holds data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          bit_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CountOne;
    if (!push_ok && pop) count_d = count_q - CountOne;
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    if (ovf_clr) ovf_d = 1'b0;
  end

  always_comb begin
    rdata_d = '0;
    rhit_d  = 1'b0;
    if (iwReadAddr == pBaseAddr) begin
      rhit_d = 1'b1;
    end else if (iwReadAddr == StatusAddr) begin
      rhit_d  = 1'b1;
      rdata_d = status;
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      rhit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      rhit_q   <= rhit_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge iwClk) begin
    if (push_ok) mem_q[wr_ptr_q] <= iwWriteData[7:0];
  end

  assign owTx       = tx_q;
  assign owReadData = rdata_q;
  assign owReadHit  = rhit_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: bytes pushed are queued as expectations and matched
// against frames decoded from the serial line by a free-running receiver process.
module tb_uart_tx_mmio;

  localparam logic [31:0] Base   = 32'h0000_1000;
  localparam logic [31:0] Stat   = Base + 32'd4;
  localparam int unsigned ClkDiv = 4;
  localparam int unsigned Depth  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] waddr = '0, wdata = '0, raddr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        rhit, tx;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned rst_cnt = 0;
  logic [7:0]  exp_q[$];
  int unsigned starts_q[$];
  bit          mon_busy = 1'b0;

  uart_tx_mmio #(
    .pBaseAddr(Base),
    .pClkDiv  (ClkDiv),
    .pDepth   (Depth)
  ) dut (
    .iwClk      (clk),
    .iwRst      (rst),
    .iwWriteAddr(waddr),
    .iwWriteData(wdata),
    .iwWstrb    (wstrb),
    .iwReadAddr (raddr),
    .owReadData (rdata),
    .owReadHit  (rhit),
    .owTx       (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns #1 after the edge that samples the write.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr = a;
    wdata = d;
    wstrb = s;
    @(posedge clk);
    #1;
    waddr = '0;
    wdata = '0;
    wstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    raddr = a;
    @(posedge clk);
    #1;
    d = rdata;
    h = rhit;
    raddr = '0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Receiver: samples each bit mid-period on falling edges; frames overlapping a reset are dropped.
  initial begin
    logic [7:0]  d;
    logic        sb, pb;
    int unsigned rc;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        rc = rst_cnt;
        starts_q.push_back(cyc);
        repeat (2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (ClkDiv) @(negedge clk);
          d[i] = tx;
        end
        repeat (ClkDiv) @(negedge clk);
        pb = tx;
        @(negedge clk);
        if (rc == rst_cnt) begin
          check("start_bit", 32'(sb), 32'd0);
          check("stop_bit", 32'(pb), 32'd1);
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("frame_data", 32'(d), 32'(exp_q.pop_front()));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic        h;
    int unsigned push_edge, diff, lows;

    // Reset with a status read and a write pending: neither may take effect.
    raddr = Stat;
    waddr = Base;
    wdata = 32'h0000_00EE;
    wstrb = 4'h1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_hit", 32'(rhit), 32'd0);
    check("rst_read_data", rdata, 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    raddr = '0;
    waddr = '0;
    wdata = '0;
    wstrb = '0;

    rd(Stat, d, h);
    check("idle_status_hit", 32'(h), 32'd1);
    check("idle_status", d, 32'h0000_0002);
    rd(32'h0, d, h);
    check("other_addr_hit", 32'(h), 32'd0);
    check("other_addr_data", d, 32'd0);
    rd(Base, d, h);
    check("data_addr_hit", 32'(h), 32'd1);
    check("data_addr_data", d, 32'd0);

    // Single frame and push-to-start latency.
    starts_q.delete();
    wr(Base, 32'hFFFF_FF55, 4'h1);
    exp_q.push_back(8'h55);
    push_edge = cyc;
    idle(5);
    rd(Stat, d, h);
    check("busy_mid_frame", d, 32'h0000_0006);
    wait_drain("drain_55", 200);
    diff = (starts_q.size() > 0) ? starts_q[0] - push_edge : 0;
    check("start_latency", diff, 32'd2);
    rd(Stat, d, h);
    check("status_after_55", d, 32'h0000_0002);

    // Two consecutive pushes give back-to-back frames.
    starts_q.delete();
    wr(Base, 32'h0000_00A5, 4'h1);
    exp_q.push_back(8'hA5);
    wr(Base, 32'h0000_003C, 4'h1);
    exp_q.push_back(8'h3C);
    wait_drain("drain_b2b", 300);
    check("b2b_frames", 32'(starts_q.size()), 32'd2);
    diff = (starts_q.size() > 1) ? starts_q[1] - starts_q[0] : 0;
    check("b2b_spacing", diff, 32'd40);
    rd(Stat, d, h);
    check("status_after_b2b", d, 32'h0000_0002);

    // Writes that must not push.
    starts_q.delete();
    wr(Base, 32'h0000_0077, 4'b0010);
    wr(Base + 32'd8, 32'h0000_0011, 4'hF);
    idle(60);
    check("no_push_frames", 32'(starts_q.size()), 32'd0);
    rd(Stat, d, h);
    check("no_push_status", d, 32'h0000_0002);

    // Overflow while the serialiser is mid-frame.
    wr(Base, 32'h0000_0011, 4'h1);
    exp_q.push_back(8'h11);
    idle(2);
    for (int i = 0; i < Depth + 2; i++) begin
      wr(Base, 32'h20 + i, 4'h1);
      if (i < Depth) exp_q.push_back(8'(32'h20 + i));
    end
    rd(Stat, d, h);
    check("status_overflow", d, 32'h0000_080D);
    wr(Stat, 32'h0000_0008, 4'h1);
    rd(Stat, d, h);
    check("status_ovf_cleared", d, 32'h0000_0805);
    wait_drain("drain_full", 800);
    rd(Stat, d, h);
    check("status_after_full", d, 32'h0000_0002);

    // Reset during data bit 3 of a frame (bit 3 of 0x52 is 0), with a second byte queued.
    wr(Base, 32'h0000_0052, 4'h1);
    push_edge = cyc;
    wr(Base, 32'h0000_00C3, 4'h1);
    exp_q.push_back(8'h52);
    exp_q.push_back(8'hC3);
    idle(int'(push_edge + 18 - cyc));
    check("tx_bit3_before_rst", 32'(tx), 32'd0);
    rst = 1'b1;
    waddr = Base;
    wdata = 32'h0000_00EE;
    wstrb = 4'h1;
    @(posedge clk);
    #1;
    check("tx_after_rst", 32'(tx), 32'd1);
    rst = 1'b0;
    waddr = '0;
    wdata = '0;
    wstrb = '0;
    exp_q.delete();
    rd(Stat, d, h);
    check("status_after_rst", d, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    @(posedge clk);
    #1;
    check("line_idle_after_rst", lows, 32'd0);
    wr(Base, 32'h0000_0096, 4'h1);
    exp_q.push_back(8'h96);
    wait_drain("drain_after_rst", 200);
    rd(Stat, d, h);
    check("status_final", d, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
